accel_ctl: RTL and testbench

Accelerator mode controller clocked by CLK_FSB. It synchronizes the 68000 reset line, nIPL2 and the DIP switches, and debounces the switches. It decides once per power-up whether acceleration is disabled, which is done by holding the interrupt switch during the first reset. It drives Disable/Park to the FSB and IOBM stages, and the oscillator-select and ROM-enable lines that the top level currently derives directly from SW. Clock and ROM selection change only while the 68000 is held in reset and no FSB cycle is active.

---
 rtl/accel_ctl.sv | 88 ++++++++
 tb/tb_accel_ctl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/accel_ctl.sv
// accel_ctl: accelerator mode controller; synchronizes reset/IPL/switches, latches Disable
// once per power-up and commits debounced switch settings only while the 68000 is in reset.
module accel_ctl #(
    parameter int DEB_CYC  = 1024,
    parameter int IPL_HOLD = 16,
    parameter int RES_MIN  = 3
) (
    input  logic       CLK_FSB,
    input  logic       RES,
    input  logic       nRES,
    input  logic       nIPL2,
    input  logic [2:0] SW,
    input  logic       BACT,
    output logic       RESs,
    output logic       RESDone,
    output logic       Disable,
    output logic       Park,
    output logic       CLK20EN,
    output logic       CLK25EN,
    output logic       MotherboardROMEN,
    output logic [2:0] SWd
);
    localparam int RW = $clog2(RES_MIN + 1);
    localparam int IW = $clog2(IPL_HOLD + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [RW-1:0] RES_MAX = RW'(RES_MIN);
    localparam logic [IW-1:0] IPL_MAX = IW'(IPL_HOLD);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);

    logic          r_res_s1, r_res_s2, r_ipl_s1, r_ipl_s2;
    logic [2:0]    r_sw_s1, r_sw_s2, r_sw_cand, r_swd;
    logic [RW-1:0] r_res_cnt;
    logic [IW-1:0] r_ipl_cnt;
    logic [DW-1:0] r_deb_cnt;
    logic          r_resdone, r_dispend, r_disable;
    logic          w_ipl_cond, w_ipl_full, w_dis_req, w_sw_diff, w_sw_stable, w_commit;

    assign w_ipl_cond  = r_res_s2 & r_ipl_s2 & ~r_resdone;
    assign w_ipl_full  = r_ipl_cnt == IPL_MAX;
    // Disable may follow on the same edge that DisPend is being set
    assign w_dis_req   = r_dispend | w_ipl_full;
    assign w_sw_diff   = r_sw_s2 != r_sw_cand;
    assign w_sw_stable = r_deb_cnt == DEB_MAX;
    assign w_commit    = w_sw_stable & ~w_sw_diff & (r_sw_cand != r_swd) & r_res_s2 & ~BACT;

    always_ff @(posedge CLK_FSB) begin
        if (RES) begin
            r_res_s1  <= 1'b0;
            r_res_s2  <= 1'b0;
            r_ipl_s1  <= 1'b0;
            r_ipl_s2  <= 1'b0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_cand <= '0;
            r_swd     <= '0;
            r_res_cnt <= '0;
            r_ipl_cnt <= '0;
            r_deb_cnt <= '0;
            r_resdone <= 1'b0;
            r_dispend <= 1'b0;
            r_disable <= 1'b0;
        end else begin
            r_res_s1  <= ~nRES;
            r_res_s2  <= r_res_s1;
            r_ipl_s1  <= ~nIPL2;
            r_ipl_s2  <= r_ipl_s1;
            r_sw_s1   <= SW;
            r_sw_s2   <= r_sw_s1;
            r_res_cnt <= !r_res_s2 ? '0 : (r_res_cnt == RES_MAX) ? r_res_cnt : r_res_cnt + 1'b1;
            r_resdone <= r_resdone | (~r_res_s2 & (r_res_cnt == RES_MAX));
            r_ipl_cnt <= !w_ipl_cond ? '0 : w_ipl_full ? r_ipl_cnt : r_ipl_cnt + 1'b1;
            r_dispend <= r_dispend | w_ipl_full;
            r_disable <= r_disable | (w_dis_req & ~BACT);
            r_sw_cand <= r_sw_s2;
            r_deb_cnt <= w_sw_diff ? '0 : w_sw_stable ? r_deb_cnt : r_deb_cnt + 1'b1;
            r_swd     <= w_commit ? r_sw_cand : r_swd;
        end
    end

    assign RESs             = r_res_s2;
    assign RESDone          = r_resdone;
    assign Disable          = r_disable;
    assign Park             = ~r_disable;
    assign SWd              = r_swd;
    assign CLK20EN          = r_swd[0];
    assign CLK25EN          = ~r_swd[0];
    assign MotherboardROMEN = ~r_swd[1];
endmodule

// File: tb/tb_accel_ctl.sv
// tb_accel_ctl: scoreboard bench for accel_ctl; expected Disable rises and SWd commits are
// queued with the stimulus and popped when the DUT output changes.
module tb_accel_ctl;
    logic       CLK_FSB = 1'b0;
    logic       RES = 1'b1, nRES = 1'b1, nIPL2 = 1'b1, BACT = 1'b0;
    logic [2:0] SW = 3'b000;
    logic       RESs, RESDone, Disable, Park, CLK20EN, CLK25EN, MotherboardROMEN;
    logic [2:0] SWd;
    int         n_pass = 0, n_chk = 0;
    logic [2:0] swd_q[$];
    logic       dis_q[$];
    logic [2:0] prev_swd;
    logic       prev_dis;
    logic [2:0] bounce[3] = '{3'b011, 3'b010, 3'b011};

    accel_ctl #(.DEB_CYC(8), .IPL_HOLD(4), .RES_MIN(3)) dut (
        .CLK_FSB(CLK_FSB), .RES(RES), .nRES(nRES), .nIPL2(nIPL2), .SW(SW), .BACT(BACT),
        .RESs(RESs), .RESDone(RESDone), .Disable(Disable), .Park(Park),
        .CLK20EN(CLK20EN), .CLK25EN(CLK25EN), .MotherboardROMEN(MotherboardROMEN), .SWd(SWd)
    );

    always #5 CLK_FSB = ~CLK_FSB;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK_FSB);
        #1;
    endtask

    task automatic pulse_res;
        RES = 1'b1;
        step(2);
        RES = 1'b0;
    endtask

    always @(negedge CLK_FSB) begin
        if (RES) begin
            prev_swd = SWd;
            prev_dis = Disable;
        end else begin
            if (SWd !== prev_swd) begin
                if (swd_q.size() == 0) chk("swd_unexpected", SWd, prev_swd);
                else chk("swd_commit", SWd, swd_q.pop_front());
                prev_swd = SWd;
            end
            if (Disable !== prev_dis) begin
                if (dis_q.size() == 0) chk("dis_unexpected", Disable, prev_dis);
                else chk("dis_rise", Disable, dis_q.pop_front());
                prev_dis = Disable;
            end
        end
    end

    initial begin
        step(2);
        RES = 1'b0;
        chk("rst_ress", RESs, 0);
        chk("rst_resdone", RESDone, 0);
        chk("rst_disable", Disable, 0);
        chk("rst_park", Park, 1);
        chk("rst_swd", SWd, 0);
        chk("rst_clk20", CLK20EN, 0);
        chk("rst_clk25", CLK25EN, 1);
        chk("rst_mbrom", MotherboardROMEN, 1);
        step(20);
        chk("idle_resdone", RESDone, 0);
        chk("idle_ress", RESs, 0);

        // reset with interrupt switch held: Disable at cycle 7
        dis_q.push_back(1'b1);
        nRES = 1'b0;
        nIPL2 = 1'b0;
        step(6);
        chk("dis_early", Disable, 0);
        chk("ress_on", RESs, 1);
        nRES = 1'b1;
        step(1);
        chk("dis_c7", Disable, 1);
        chk("park_c7", Park, 0);
        step(3);
        chk("resdone_1", RESDone, 1);
        nIPL2 = 1'b1;
        nRES = 1'b0;
        step(6);
        nRES = 1'b1;
        step(4);
        chk("dis_sticky", Disable, 1);

        // short reset pulse does not qualify
        pulse_res();
        nRES = 1'b0;
        step(2);
        nRES = 1'b1;
        step(6);
        chk("short_resdone", RESDone, 0);
        nRES = 1'b0;
        step(6);
        nRES = 1'b1;
        step(4);
        chk("long_resdone", RESDone, 1);
        chk("long_disable", Disable, 0);

        // nIPL2 released one cycle short of the hold count restarts it
        pulse_res();
        nRES = 1'b0;
        nIPL2 = 1'b0;
        step(3);
        nIPL2 = 1'b1;
        step(2);
        nIPL2 = 1'b0;
        dis_q.push_back(1'b1);
        step(6);
        chk("restart_dis0", Disable, 0);
        step(1);
        chk("restart_dis1", Disable, 1);
        nRES = 1'b1;
        nIPL2 = 1'b1;
        step(4);

        // BACT stalls Disable without losing the request
        pulse_res();
        BACT = 1'b1;
        nRES = 1'b0;
        nIPL2 = 1'b0;
        dis_q.push_back(1'b1);
        step(10);
        chk("bact_stall", Disable, 0);
        BACT = 1'b0;
        step(1);
        chk("bact_release", Disable, 1);
        nRES = 1'b1;
        nIPL2 = 1'b1;
        step(4);

        // switch change outside reset stays pending until reset
        pulse_res();
        SW = 3'b001;
        step(20);
        chk("sw_outside", SWd, 0);
        chk("sw_outside_clk20", CLK20EN, 0);
        swd_q.push_back(3'b001);
        nRES = 1'b0;
        step(4);
        chk("sw_commit1", SWd, 3'b001);
        chk("sw_clk20", CLK20EN, 1);
        chk("sw_clk25", CLK25EN, 0);

        // bouncing switch never commits; then a stable 010 does
        foreach (bounce[i]) begin
            SW = bounce[i];
            step(5);
        end
        chk("bounce_swd", SWd, 3'b001);
        SW = 3'b010;
        swd_q.push_back(3'b010);
        step(12);
        chk("sw_commit2", SWd, 3'b010);
        chk("sw_mbrom", MotherboardROMEN, 0);
        chk("sw_clk20_off", CLK20EN, 0);
        nRES = 1'b1;
        step(4);

        chk("swd_q_empty", swd_q.size(), 0);
        chk("dis_q_empty", dis_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
